fifo_ctrl: RTL
==============

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, data word width matching the 16x10 memory array.
REQ-002 The block SHALL have parameter ADDR_W, default 4, pointer width; depth = 2**ADDR_W = 16.
REQ-003 The block SHALL have parameter AF_THR, default 14, almost-full occupancy threshold.
REQ-004 The block SHALL have parameter AE_THR, default 2, almost-empty occupancy threshold.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous reset, active high.
REQ-008 push  input  1  upstream write request.
REQ-009 pop  input  1  downstream read request.
REQ-010 data_in  input  DATA_W  upstream write data.
REQ-011 wr_en  output  1  write strobe to the memory array.
REQ-012 wr_add  output  ADDR_W  write address to the memory array.
REQ-013 data_to_mem  output  DATA_W  write data to the memory array.
REQ-014 rd_en  output  1  read strobe to the memory array.
REQ-015 rd_add  output  ADDR_W  read address to the memory array.
REQ-016 data_valid  output  1  memory read data is valid this cycle.
REQ-017 count  output  ADDR_W+1  current occupancy, 0..16.
REQ-018 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-019 overflow, underflow  output  1 each  sticky error flags.
REQ-020 state  output  2  controller state: EMPTY=0, PARTIAL=1, FULL=2, ERROR=3.

Function
REQ-021 wr_en SHALL equal push & ~full, combinationally; wr_add SHALL equal wr_ptr; data_to_mem SHALL equal data_in.
REQ-022 rd_en SHALL equal pop & ~empty, combinationally; rd_add SHALL equal rd_ptr.
REQ-023 wr_ptr SHALL increment by 1 on each clock edge with wr_en=1, wrapping 15->0; rd_ptr SHALL do the same on rd_en=1.
REQ-024 count SHALL be +1 on wr_en only, -1 on rd_en only, and unchanged on both or neither.
REQ-025 Simultaneous push and pop with 0<count<16 SHALL perform both; count SHALL stay unchanged.
REQ-026 When full, push SHALL be rejected even if pop is asserted in the same cycle; only the pop SHALL occur.
REQ-027 When empty, pop SHALL be rejected even if push is asserted in the same cycle; only the push SHALL occur.
REQ-028 data_valid SHALL be rd_en registered by one cycle, matching the memory's one-cycle read latency.
REQ-029 Flags SHALL be combinational from count: full=(count==16), empty=(count==0), almost_full=(count>=AF_THR), almost_empty=(count<=AE_THR).
REQ-030 overflow SHALL set on the edge after push & full; underflow SHALL set on the edge after pop & empty; both SHALL hold until reset.
REQ-031 State transitions: EMPTY->PARTIAL on a write; PARTIAL->FULL when count reaches 16; PARTIAL->EMPTY when count reaches 0; FULL->PARTIAL on a read.
REQ-032 Any state SHALL go to ERROR when overflow or underflow sets; ERROR SHALL leave only on reset.
REQ-033 In ERROR, FIFO operation (strobes, pointers, count) SHALL continue normally; only state is frozen.

Reset
REQ-034 Reset assertion SHALL immediately, without a clock, force wr_ptr=0, rd_ptr=0, count=0, data_valid=0, overflow=0, underflow=0, state=EMPTY.
REQ-035 Consequently, during reset empty=1, almost_empty=1, full=0, almost_full=0, wr_add=0, rd_add=0.
REQ-036 Reset asserted mid-transfer SHALL discard all occupancy; memory contents need not be cleared.
REQ-037 wr_en and rd_en SHALL be forced to 0 while reset=1.

Verification
REQ-038 Scenario: after reset, 16 pushes of data 0x001..0x010 -> wr_add 0..15, count=16, full=1, almost_full=1 from count 14, state=FULL.
REQ-039 Scenario: 16 pops from full -> rd_add 0..15, data_valid one cycle after each rd_en, memory read data 0x001..0x010 in order, ending empty=1, state=EMPTY.
REQ-040 Scenario: push+pop together at count=5 for 20 cycles -> count stays 5, both pointers wrap 15->0, read data is correct.
REQ-041 Scenario: push at full with pop=1 -> wr_en=0, rd_en=1, count 16->15, overflow=1, state=ERROR.
REQ-042 Scenario: pop at empty with push=1 -> rd_en=0, wr_en=1, count=1, underflow=1, state=ERROR.
REQ-043 Scenario: reset pulse between clock edges at count=9 -> count=0 and empty=1 immediately; the next push writes wr_add=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy, flag and state control for an external 2**ADDR_W x DATA_W FIFO memory
module fifo_ctrl #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4,
  parameter int AF_THR = 14,
  parameter int AE_THR = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_add,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_add,
  output logic              data_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL, ST_ERROR} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C = AF_THR[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C = AE_THR[ADDR_W:0];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic valid_q, ovf_q, ovf_d, unf_q, unf_d;
  logic ovf_ev, unf_ev;
  state_t state_q, state_d;
  assign full = count_q == DEPTH;
  assign empty = count_q == '0;
  assign almost_full = count_q >= AF_C;
  assign almost_empty = count_q <= AE_C;
  assign wr_en = push & ~full & ~reset;
  assign rd_en = pop & ~empty & ~reset;
  assign wr_add = wr_ptr_q;
  assign rd_add = rd_ptr_q;
  assign data_to_mem = data_in;
  assign data_valid = valid_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  assign state = state_q;
  assign ovf_ev = push & full;
  assign unf_ev = pop & empty;
  // next pointers, occupancy, sticky errors and controller state
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (wr_en & ~rd_en) ? count_q + 1'b1 : (rd_en & ~wr_en) ? count_q - 1'b1 : count_q;
    ovf_d = ovf_q | ovf_ev;
    unf_d = unf_q | unf_ev;
    state_d = (state_q == ST_ERROR || ovf_ev || unf_ev) ? ST_ERROR :
              count_d == DEPTH ? ST_FULL : count_d == '0 ? ST_EMPTY : ST_PARTIAL;
  end
  // datapath registers; reset discards all occupancy without touching memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      valid_q <= rd_en;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // controller state; ERROR is left only through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else state_q <= state_d;
  end
endmodule
